// File: rtl/t_counter_using_sr_if.sv
// Handshake bundle for the SR-flip-flop counter: control and load value in,
// count and status flags out.
interface t_counter_using_sr_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             sr_fault;

    modport master (
        output en, up, load, d,
        input  q, tc, wrap, sr_fault
    );

    modport slave (
        input  en, up, load, d,
        output q, tc, wrap, sr_fault
    );
endinterface

// File: rtl/t_counter_using_sr.sv
// Modulo-MODULUS up/down counter whose state bits are SR flip-flops excited
// through T-to-SR logic; adds saturating load, terminal count, wrap pulse and a sticky S&R monitor.
module t_counter_using_sr #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic                  clk,
    input  logic                  cr,
    t_counter_using_sr_if.slave   bus
);
    // Compare/increment width is one bit wider so MODULUS = 2**WIDTH is representable.
    localparam logic [WIDTH:0] LAST    = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] s_vec;
    logic [WIDTH-1:0] r_vec;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   d_ext;
    logic             at_last;
    logic             at_zero;
    logic             tc_next;
    logic             wrap_reg;
    logic             sr_fault_reg;

    assign q_ext   = {1'b0, q_reg};
    assign d_ext   = {1'b0, bus.d};
    assign at_last = (q_ext == LAST);
    assign at_zero = (q_ext == '0);

    assign tc_next = ~bus.load & bus.en &
                     ((bus.up & at_last) | (~bus.up & at_zero));

    // An out-of-range state counting up falls to 0, so the counter cannot lock up.
    always_comb begin
        q_next = q_reg;
        if (bus.load) begin
            q_next = (d_ext >= MOD_EXT) ? WIDTH'(LAST) : bus.d;
        end else if (bus.en) begin
            if (bus.up) begin
                q_next = (q_ext >= LAST) ? '0 : WIDTH'(q_ext + 1'b1);
            end else begin
                q_next = at_zero ? WIDTH'(LAST) : WIDTH'(q_ext - 1'b1);
            end
        end
    end

    assign t_vec = q_reg ^ q_next;
    assign s_vec = t_vec & ~q_reg;
    assign r_vec = t_vec &  q_reg;

    // One SR flip-flop per state bit; S and R together is illegal and holds.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sr_bit
            logic q_bit_reg;

            always_ff @(posedge clk or negedge cr) begin
                if (!cr) begin
                    q_bit_reg <= 1'b0;
                end else begin
                    case ({s_vec[gi], r_vec[gi]})
                        2'b10:   q_bit_reg <= 1'b1;
                        2'b01:   q_bit_reg <= 1'b0;
                        default: q_bit_reg <= q_bit_reg;
                    endcase
                end
            end

            assign q_reg[gi] = q_bit_reg;
        end
    endgenerate

    // tc already excludes load, so a load can never raise wrap.
    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            wrap_reg     <= 1'b0;
            sr_fault_reg <= 1'b0;
        end else begin
            wrap_reg <= tc_next;
            if (|(s_vec & r_vec)) begin
                sr_fault_reg <= 1'b1;
            end
        end
    end

    assign bus.q        = q_reg;
    assign bus.tc       = tc_next;
    assign bus.wrap     = wrap_reg;
    assign bus.sr_fault = sr_fault_reg;
endmodule
